demux_ch_sequencer: RTL and testbench
=====================================

Name: demux_ch_sequencer

Overview:
- Upstream feeder for the team's 1-to-8 single-bit demultiplexer.
- Accepts one 8-bit word plus an 8-bit channel-enable mask through a valid/ready handshake.
- Walks the enabled channels in ascending order, driving the demux select and data bit for each channel. Each channel is held for a programmable dwell time.
- Produces per-channel strobe, busy and done-pulse status so downstream per-channel capture logic knows when each demux output is valid.

Parameters:
- DWELL, 2, cycles each enabled channel is held on the demux; legal range 1..255.
- NUM_CH, 8, channel count; fixed at 8 for this revision, carried in the package.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  8  bit i is routed to demux output i.
- in_mask  in  8  bit i=1 means channel i is visited; 0 means it is skipped.
- abort  in  1  synchronous cancel of the word in flight.
- sel  out  3  demux select.
- data_bit  out  1  demux data input; equals latched in_data[sel].
- strobe  out  1  high while sel/data_bit present a valid enabled channel.
- busy  out  1  word in flight (SCAN or DONE state).
- done  out  1  one-cycle pulse when a word completes normally.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; sel=0, data_bit=0, strobe=0, busy=0, done=0; dwell counter and latched data/mask cleared. in_ready=1 from the first cycle after rst_n is sampled high.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data and in_mask.
  - If in_mask!=0: go to SCAN with sel = lowest set mask bit.
  - If in_mask==0: go directly to DONE.
  - in_valid while not in IDLE is ignored (in_ready=0); upstream must hold in_valid.
- SCAN:
  - strobe=1, busy=1, in_ready=0.
  - sel and data_bit are stable for exactly DWELL cycles per channel.
  - Dwell counter runs 0..DWELL-1. At terminal count, sel advances to the next set mask bit above the current sel.
  - If no set bit remains, go to DONE; no wrap-around to channel 0.
- DONE:
  - Lasts one cycle: done=1, busy=1, strobe=0, in_ready=0.
  - Next state is IDLE.
- Latency:
  - Handshake at edge k: first channel visible at cycle k+1.
  - Busy lasts N*DWELL+1 cycles, with N = popcount(mask).
  - Next accept is possible at cycle k+N*DWELL+2.
- abort:
  - Highest priority after reset. Sampled high in SCAN or DONE: next state IDLE, strobe=0, busy=0, done=0 (no done pulse).
  - Latched data/mask are cleared.
  - abort in IDLE suppresses acceptance that cycle (in_ready forced 0 while abort=1).
- Outputs outside SCAN:
  - sel holds its last value.
  - data_bit is driven 0.
- All outputs are registered except in_ready, which is decoded from state and abort.
- Reset mid-word: identical to the abort result, with reset values applied.

Decomposition:
- Package demux_seq_pkg:
  - NUM_CH=8 and SEL_W=3.
  - state enum {IDLE, SCAN, DONE}.
  - popcount helper function.
- One natural sub-module, demux_next_ch: combinational find-next-set-bit.
  - Inputs: mask[7:0] and cur[2:0]; a start flag selects search-from-bit-0.
  - Outputs: nxt[2:0] and found.
  - Reused by downstream capture logic.

Test Plan:
- Reset, then in_data=8'hA5, in_mask=8'hFF, DWELL=2 -> sel steps 0..7, each held 2 cycles. data_bit sequence 1,0,1,0,0,1,0,1. strobe high 16 cycles. done pulses at cycle k+17. in_ready high again at k+18.
- in_mask=8'h81, in_data=8'h80 -> only sel=0 (data_bit 0) then sel=7 (data_bit 1), 2 cycles each. busy=5 cycles.
- in_mask=8'h00 -> no strobe; done pulses at cycle k+1; in_ready=1 at k+2.
- abort asserted during third channel of mask 8'hFF -> next cycle IDLE, strobe=0, busy=0, no done pulse. A new word is accepted the following cycle.
- rst_n low for one cycle mid-SCAN -> all outputs at reset values next cycle; in_ready=1 the cycle after rst_n returns high.
- in_valid held high back-to-back with two words, DWELL=1 -> second word accepted exactly one cycle after the first word's done pulse. No word is dropped or duplicated (scoreboard on sel/data_bit).

Source files
------------

// File: rtl/demux_ch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// demux_seq_pkg
// Shared definitions for the demux channel sequencer and its helpers.
//   NUM_CH   : number of demux outputs served by the sequencer
//   SEL_W    : width of the demux select
//   CNT_W    : width wide enough to hold a channel count 0..NUM_CH
//   state_t  : sequencer FSM states (IDLE, SCAN, DONE)
//   popcount : number of enabled channels in a mask
// ---------------------------------------------------------------------------
package demux_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counts enabled channels; downstream logic uses it to size capture
    // windows (busy lasts popcount*DWELL+1 cycles).
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/demux_ch_sequencer_if.sv
// ---------------------------------------------------------------------------
// demux_ch_sequencer_if
// Bundles the word handshake, abort and demux-side outputs of the sequencer.
//   in_valid/in_ready : upstream word handshake
//   in_data/in_mask   : word bits and channel-enable mask
//   abort             : synchronous cancel of the word in flight
//   sel/data_bit      : demux select and data input
//   strobe/busy/done  : per-channel status for downstream capture logic
// Modports: master (upstream feeder / testbench), slave (sequencer).
// ---------------------------------------------------------------------------
interface demux_ch_sequencer_if;
    import demux_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [NUM_CH-1:0] in_data;
    logic [NUM_CH-1:0] in_mask;
    logic              abort;
    logic [SEL_W-1:0]  sel;
    logic              data_bit;
    logic              strobe;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, in_data, in_mask, abort,
        input  in_ready, sel, data_bit, strobe, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_mask, abort,
        output in_ready, sel, data_bit, strobe, busy, done
    );

endinterface

// File: rtl/demux_ch_sequencer_next_ch.sv
// ---------------------------------------------------------------------------
// demux_next_ch
// Combinational find-next-set-bit over a channel mask.
//   i_mask  : channel-enable mask
//   i_cur   : current channel; search starts strictly above it
//   i_start : when high, search from bit 0 inclusive and ignore i_cur
//   o_nxt   : lowest qualifying set bit (0 when none)
//   o_found : a qualifying set bit exists
// No wrap-around: once the highest set bit is passed, o_found drops.
// ---------------------------------------------------------------------------
module demux_next_ch
    import demux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_cur,
    input  logic              i_start,
    output logic [SEL_W-1:0]  o_nxt,
    output logic              o_found
);

    // Scan from the top down so that the last hit written is the lowest
    // qualifying bit, which gives ascending channel order.
    always_comb begin
        o_nxt   = '0;
        o_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_start || (i > int'(i_cur)))) begin
                o_nxt   = SEL_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_ch_sequencer.sv
// ---------------------------------------------------------------------------
// demux_ch_sequencer
// Upstream feeder for the 1-to-8 single-bit demux. Accepts a data word and a
// channel-enable mask, then walks the enabled channels in ascending order,
// holding each on the demux for DWELL cycles.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : demux_ch_sequencer_if.slave (handshake, abort, demux outputs)
// Parameter DWELL: cycles each enabled channel is held (legal 1..255).
// All outputs are registered except in_ready, decoded from state and abort.
// ---------------------------------------------------------------------------
module demux_ch_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_ch_sequencer_if.slave  bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_n;
    logic [NUM_CH-1:0] r_data;
    logic [NUM_CH-1:0] w_data_n;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] w_mask_n;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_n;
    logic              r_data_bit;
    logic              w_data_bit_n;
    logic              r_strobe;
    logic              w_strobe_n;
    logic              r_busy;
    logic              w_busy_n;
    logic              r_done;
    logic              w_done_n;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_dwell_end;
    logic              w_search_start;
    logic [NUM_CH-1:0] w_search_mask;
    logic [SEL_W-1:0]  w_nxt;
    logic              w_found;

    // in_ready is gated by rst_n so no handshake can appear to complete
    // while the block is being held in reset.
    assign w_in_ready  = rst_n && (r_state == IDLE) && !bus.abort;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_dwell_end = (r_cnt == 8'(DWELL - 1));

    // One search unit serves both cases: in IDLE it finds the first channel
    // of the incoming mask, in SCAN it finds the channel after r_sel.
    assign w_search_start = (r_state == IDLE);
    assign w_search_mask  = w_search_start ? bus.in_mask : r_mask;

    demux_next_ch u_next_ch (
        .i_mask  (w_search_mask),
        .i_cur   (r_sel),
        .i_start (w_search_start),
        .o_nxt   (w_nxt),
        .o_found (w_found)
    );

    // State register; reset returns the sequencer to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode. An all-zero mask skips SCAN and goes straight to
    // DONE so upstream still sees a completion pulse. abort overrides
    // everything and drops back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_found ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (w_dwell_end && !w_found) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (bus.abort) begin
            w_next_state = IDLE;
        end
    end

    // Output decode: computes the next value of every registered output and
    // of the dwell counter and latches. Outside SCAN data_bit is forced to 0
    // while sel keeps its last value so the demux select does not glitch.
    always_comb begin
        w_cnt_n      = '0;
        w_sel_n      = r_sel;
        w_data_bit_n = 1'b0;
        w_strobe_n   = 1'b0;
        w_busy_n     = 1'b0;
        w_done_n     = 1'b0;
        w_data_n     = r_data;
        w_mask_n     = r_mask;
        if (bus.abort) begin
            w_data_n = '0;
            w_mask_n = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_data_n = bus.in_data;
                        w_mask_n = bus.in_mask;
                        w_busy_n = 1'b1;
                        if (w_found) begin
                            w_sel_n      = w_nxt;
                            w_data_bit_n = bus.in_data[w_nxt];
                            w_strobe_n   = 1'b1;
                        end else begin
                            w_done_n = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    w_busy_n = 1'b1;
                    if (!w_dwell_end) begin
                        w_cnt_n      = r_cnt + 8'd1;
                        w_data_bit_n = r_data[r_sel];
                        w_strobe_n   = 1'b1;
                    end else if (w_found) begin
                        w_sel_n      = w_nxt;
                        w_data_bit_n = r_data[w_nxt];
                        w_strobe_n   = 1'b1;
                    end else begin
                        w_done_n = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers for outputs, dwell counter and latched word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_sel      <= '0;
            r_data_bit <= 1'b0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_mask     <= '0;
        end else begin
            r_cnt      <= w_cnt_n;
            r_sel      <= w_sel_n;
            r_data_bit <= w_data_bit_n;
            r_strobe   <= w_strobe_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_data     <= w_data_n;
            r_mask     <= w_mask_n;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.sel      = r_sel;
    assign bus.data_bit = r_data_bit;
    assign bus.strobe   = r_strobe;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_demux_ch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_demux_ch_sequencer
// Two sequencer instances: DUT A with DWELL=2 and DUT B with DWELL=1. Words
// are pushed into a per-DUT expected-event queue as they are accepted; a
// negedge monitor pops and compares whenever strobe or done is presented.
// ---------------------------------------------------------------------------
module tb_demux_ch_sequencer;

    localparam int DWELL_A = 2;
    localparam int DWELL_B = 1;

    typedef struct packed {
        logic       isDone;
        logic [2:0] sel;
        logic       dbit;
    } ev_t;

    typedef struct packed {
        logic       ready;
        logic       strobe;
        logic       busy;
        logic       done;
        logic       dbit;
        logic [2:0] sel;
    } out_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vecCount;
    int   missCount;
    int   hsCyc;
    int   doneCyc [2];
    ev_t  qA [$];
    ev_t  qB [$];

    demux_ch_sequencer_if busA ();
    demux_ch_sequencer_if busB ();

    demux_ch_sequencer #(.DWELL(DWELL_A)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    demux_ch_sequencer #(.DWELL(DWELL_B)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    // Free-running clock and cycle counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case a wait ever runs away.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic out_t sample(input int w);
        out_t s;
        if (w == 0) begin
            s.ready = busA.in_ready; s.strobe = busA.strobe; s.busy = busA.busy;
            s.done  = busA.done;     s.dbit   = busA.data_bit; s.sel = busA.sel;
        end else begin
            s.ready = busB.in_ready; s.strobe = busB.strobe; s.busy = busB.busy;
            s.done  = busB.done;     s.dbit   = busB.data_bit; s.sel = busB.sel;
        end
        return s;
    endfunction

    task automatic drive(input int w, input logic v, input logic [7:0] d,
                         input logic [7:0] m, input logic ab);
        if (w == 0) begin
            busA.in_valid = v; busA.in_data = d; busA.in_mask = m; busA.abort = ab;
        end else begin
            busB.in_valid = v; busB.in_data = d; busB.in_mask = m; busB.abort = ab;
        end
    endtask

    task automatic pushEv(input int w, input ev_t e);
        if (w == 0) qA.push_back(e);
        else        qB.push_back(e);
    endtask

    task automatic popEv(input int w, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        if (w == 0 && qA.size() > 0) begin e = qA.pop_front(); ok = 1'b1; end
        if (w == 1 && qB.size() > 0) begin e = qB.pop_front(); ok = 1'b1; end
    endtask

    // Reference model: every enabled channel, lowest first, is shown for
    // dwell cycles, followed by one done event. 'limit' truncates the strobe
    // list (abort/reset); a truncated word never produces done.
    task automatic pushModel(input int w, input logic [7:0] data,
                             input logic [7:0] mask, input int limit);
        int  dwell   = (w == 0) ? DWELL_A : DWELL_B;
        int  total   = $countones(mask) * dwell;
        int  emitted = 0;
        ev_t e;
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                for (int r = 0; r < dwell; r++) begin
                    if (emitted < limit) begin
                        e.isDone = 1'b0;
                        e.sel    = 3'(ch);
                        e.dbit   = data[ch];
                        pushEv(w, e);
                        emitted++;
                    end
                end
            end
        end
        if (emitted == total) begin
            e = '0;
            e.isDone = 1'b1;
            pushEv(w, e);
        end
    endtask

    // Holds in_valid with the word until in_ready is seen, then pushes the
    // expected events at the accepting edge. Must be called just after a
    // negedge; returns just after the accepting posedge with in_valid high.
    task automatic applyStimulus(input int w, input logic [7:0] data,
                                 input logic [7:0] mask, input int limit);
        bit   got = 1'b0;
        out_t s;
        for (int n = 0; n < 200 && !got; n++) begin
            if (n > 0) @(negedge clk);
            drive(w, 1'b1, data, mask, 1'b0);
            #1;
            s = sample(w);
            if (s.ready === 1'b1) got = 1'b1;
        end
        checkOutput("handshake_seen", int'(got), 1);
        if (got) begin
            hsCyc = cyc;
            @(posedge clk);
            pushModel(w, data, mask, limit);
        end
    endtask

    // Runs one complete word and checks busy length, strobe length, done
    // position and in_ready return against the latency rules.
    task automatic runWord(input int w, input logic [7:0] data, input logic [7:0] mask);
        int   dwell = (w == 0) ? DWELL_A : DWELL_B;
        int   expStrobe = $countones(mask) * dwell;
        int   busyCnt = 0;
        int   strobeCnt = 0;
        int   doneAt = -1;
        int   hs;
        bit   finished = 1'b0;
        out_t s;
        applyStimulus(w, data, mask, 100000);
        hs = hsCyc;
        @(negedge clk);
        drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 600 && !finished; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            s = sample(w);
            if (s.busy) busyCnt++;
            if (s.strobe) strobeCnt++;
            if (s.done) doneAt = cyc;
            if (!s.busy) finished = 1'b1;
        end
        checkOutput("word_finished", int'(finished), 1);
        checkOutput("busy_len", busyCnt, expStrobe + 1);
        checkOutput("strobe_len", strobeCnt, expStrobe);
        checkOutput("done_offset", doneAt - hs, expStrobe + 1);
        checkOutput("ready_after_word", int'(s.ready), 1);
    endtask

    // Scoreboard monitor: pops one expected event per presented strobe or
    // done cycle and compares select, data bit and status flags.
    task automatic monitorOne(input int w);
        out_t s;
        ev_t  e;
        bit   ok;
        s = sample(w);
        if (s.strobe === 1'b1 || s.done === 1'b1) begin
            popEv(w, e, ok);
            if (!ok) begin
                checkOutput($sformatf("unexpected_output_dut%0d", w), 1, 0);
            end else if (s.done === 1'b1) begin
                doneCyc[w] = cyc;
                checkOutput($sformatf("done_vs_model_dut%0d", w), int'(e.isDone), 1);
                checkOutput($sformatf("strobe_in_done_dut%0d", w), int'(s.strobe), 0);
                checkOutput($sformatf("data_bit_in_done_dut%0d", w), int'(s.dbit), 0);
            end else begin
                checkOutput($sformatf("strobe_vs_model_dut%0d", w), int'(e.isDone), 0);
                checkOutput($sformatf("sel_dut%0d", w), int'(s.sel), int'(e.sel));
                checkOutput($sformatf("data_bit_dut%0d", w), int'(s.dbit), int'(e.dbit));
                checkOutput($sformatf("busy_in_scan_dut%0d", w), int'(s.busy), 1);
            end
        end
    endtask

    always @(negedge clk) begin
        monitorOne(0);
        monitorOne(1);
    end

    // Main stimulus sequence.
    initial begin
        out_t        s;
        logic [7:0]  d;
        logic [7:0]  m;
        logic [7:0]  prevMask;
        int          prevHs;
        int          abortCyc;
        vecCount   = 0;
        missCount  = 0;
        doneCyc[0] = -1;
        doneCyc[1] = -1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset values while rst_n is held low.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            s = sample(w);
            checkOutput("reset_sel", int'(s.sel), 0);
            checkOutput("reset_strobe", int'(s.strobe), 0);
            checkOutput("reset_busy", int'(s.busy), 0);
            checkOutput("reset_done", int'(s.done), 0);
            checkOutput("reset_data_bit", int'(s.dbit), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("ready_after_reset_A", int'(busA.in_ready), 1);
        checkOutput("ready_after_reset_B", int'(busB.in_ready), 1);

        // Directed words on DUT A (DWELL=2).
        runWord(0, 8'hA5, 8'hFF);
        runWord(0, 8'h80, 8'h81);
        runWord(0, 8'h5A, 8'h00);

        // abort while idle blocks acceptance.
        drive(0, 1'b1, 8'h3C, 8'h3C, 1'b1);
        #1;
        checkOutput("ready_with_abort_idle", int'(busA.in_ready), 0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        checkOutput("no_accept_under_abort", int'(busA.busy), 0);

        // abort during the third channel of an all-enabled word.
        d = 8'($urandom_range(0, 255));
        applyStimulus(0, d, 8'hFF, 5);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        abortCyc = cyc;
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        s = sample(0);
        checkOutput("abort_strobe", int'(s.strobe), 0);
        checkOutput("abort_busy", int'(s.busy), 0);
        checkOutput("abort_done", int'(s.done), 0);
        applyStimulus(0, 8'h0F, 8'h06, 100000);
        checkOutput("accept_after_abort", hsCyc - abortCyc, 1);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (8) @(negedge clk);

        // One-cycle reset in the middle of a scan.
        d = 8'($urandom_range(0, 255));
        applyStimulus(0, d, 8'hFF, 7);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        s = sample(0);
        checkOutput("midreset_sel", int'(s.sel), 0);
        checkOutput("midreset_strobe", int'(s.strobe), 0);
        checkOutput("midreset_busy", int'(s.busy), 0);
        checkOutput("midreset_done", int'(s.done), 0);
        checkOutput("midreset_data_bit", int'(s.dbit), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_ready", int'(busA.in_ready), 1);

        // Random complete words on DUT A.
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 255));
            runWord(0, d, m);
        end

        // Back-to-back words on DUT B (DWELL=1) with in_valid held high.
        prevMask = 8'hC3;
        applyStimulus(1, 8'h96, prevMask, 100000);
        prevHs = hsCyc;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            m = (i == 2) ? 8'h00 : 8'($urandom_range(0, 255));
            @(negedge clk);
            applyStimulus(1, d, m, 100000);
            checkOutput("b2b_spacing", hsCyc - prevHs,
                        $countones(prevMask) * DWELL_B + 2);
            checkOutput("b2b_after_done", hsCyc - doneCyc[1], 1);
            prevHs   = hsCyc;
            prevMask = m;
        end
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Let both scoreboards drain, then every expected event must be used.
        repeat (40) @(negedge clk);
        checkOutput("queueA_drained", qA.size(), 0);
        checkOutput("queueB_drained", qB.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
